kamacore_stage_mem: RTL and testbench
=====================================

# kamacore_stage_mem

Memory-access stage of the kamacore pipeline. It consumes the EX/MEM pipeline register and performs loads and stores on the data-memory bus through a req/gnt/rvalid handshake. It aligns and sign-extends load data and formats store data and byte enables. It registers results into the MEM/WB pipeline register and stalls the upstream stages while a memory transaction is outstanding.

## Interface
- `CPU_WIDTH`, default 32: datapath width; the stage supports only 32.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `pipeline_ex_mem`  interface (`kamacore_pipeline_stage`, read side): fields used are `alu_result` (effective address or ALU value), `rs2_data` (store data), `instruction`, and `control_signals`.
- `pipeline_mem_wb`  interface (`kamacore_pipeline_stage`, write side): this stage drives `alu_result`, `mem_data`, `instruction`, and `control_signals`.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  32  word-aligned address, `{alu_result[31:2], 2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid this cycle.
- `dmem_rdata`  in  32  load data, full word.
- `stall`  out  1  holds IF/ID/EX and the EX/MEM register.
- `misaligned`  out  1  one-cycle pulse on a misaligned access.

## Operation
- Decode from `pipeline_ex_mem.instruction`: opcode `[6:0]` 0000011 = LOAD, 0100011 = STORE; width from funct3 `[14:12]`.
- Any other opcode is a pass-through: no bus activity, and the MEM/WB register loads every cycle with `mem_data = 0`.
- Misalignment is defined as:
  - H or HU access with `addr[0]` = 1.
  - W access with `addr[1:0]` ≠ 0.
- On misalignment: no request is issued, `misaligned` pulses, and the instruction passes to MEM/WB with `mem_data = 0`.
- Store formatting:
  - SB: `be = 0001 << addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - SH: `be = 0011 << (2*addr[1])`, `wdata = {2{rs2[15:0]}}`.
  - SW: `be = 1111`, `wdata = rs2`.
- Load formatting: shift `rdata` right by `8*addr[1:0]`, then:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
  - Loads drive `be` as for stores of the same width.
- FSM states:
  - IDLE: an aligned memory op present drives `dmem_req` = 1 combinationally.
    - No gnt: go to REQ.
    - gnt on a store: the store completes and the state stays IDLE.
    - gnt on a load: go to WAIT.
  - REQ: hold `req`, `addr`, `be`, `wdata`, and `we` stable until gnt; then the store completes (go to IDLE) or the load goes to WAIT.
  - WAIT: `req` = 0. On `rvalid`, capture formatted data into MEM/WB and go to IDLE.
- `stall` = 1 when a memory op is present and not completing this cycle. This covers IDLE or REQ without gnt, a load gnt, and WAIT without rvalid.
- While stalled, `pipeline_mem_wb` loads a bubble: `instruction` and `control_signals` = 0.
- `dmem_rvalid` received in IDLE or REQ is ignored.

## Timing
- Reset (`rst` = 0 at clk edge):
  - State goes to IDLE.
  - All MEM/WB fields are cleared to 0.
  - Combinational outputs `dmem_req`, `stall`, and `misaligned` are 0 while in reset.
  - A transaction in flight is abandoned; its late `rvalid` is ignored.
- Non-memory or misaligned op: MEM/WB is updated at the next edge (1-cycle latency, no stall).
- Store, gnt in cycle 0: completes in cycle 0 with no stall.
- Load, gnt in cycle 0 and rvalid in cycle 1: stall is high in cycle 0 and low in cycle 1; MEM/WB is written at the end of cycle 1.
- The earliest rvalid is the cycle after gnt. gnt and rvalid in the same cycle for the same load is illegal.
- At most one outstanding transaction.
- Back-to-back memory ops: the next request issues in the cycle after completion.

## Structure
- `kamacore_pkg` holds:
  - Opcode constants `OPC_LOAD` and `OPC_STORE`.
  - funct3 encodings `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - FSM enum `mem_state_t` with values IDLE, REQ, WAIT.
- Sub-module `kamacore_lsu_align` (combinational): takes `addr[1:0]`, funct3, `rs2`, and `rdata`; produces `be`, `wdata`, load data, and the misaligned flag.

## Test plan
- SW, addr 0x100, rs2 0xDEADBEEF, gnt same cycle → `be` = 1111, `wdata` = 0xDEADBEEF, `stall` never high.
- SB, addr 0x103, rs2 0x000000A5, gnt after 2 cycles → `stall` high for 2 cycles, `be` = 1000, `wdata` = 0xA5A5A5A5, `addr` stable throughout.
- LB, addr 0x202, rdata 0x00800000, rvalid 1 cycle after gnt → `mem_data` = 0xFFFFFF80; LBU with the same stimulus → 0x00000080.
- LW, addr 0x301 → `misaligned` pulses, `dmem_req` never high, `mem_data` = 0, no stall.
- Load in WAIT, reset asserted, late rvalid after reset → state IDLE, MEM/WB all 0, stray rvalid has no effect.
- ADD instruction, alu_result 0x1234 → MEM/WB `alu_result` = 0x1234 next edge, `dmem_req` = 0.

Source files
------------

// File: rtl/kamacore_pkg.sv
// Shared constants and types for the kamacore pipeline.
// Holds the instruction decode constants and the memory-stage FSM encoding.
package kamacore_pkg;

    localparam int CTRL_W = 16;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

endpackage

// File: rtl/kamacore_pipeline_stage.sv
// Pipeline register bundle passed between kamacore stages.
// The producing stage uses the wr modport; the consuming stage uses the rd modport.
interface kamacore_pipeline_stage
    import kamacore_pkg::*;
;
    logic [31:0]       alu_result;
    logic [31:0]       rs2_data;
    logic [31:0]       mem_data;
    logic [31:0]       instruction;
    logic [CTRL_W-1:0] control_signals;

    modport rd (input alu_result, rs2_data, instruction, control_signals);
    modport wr (output alu_result, rs2_data, mem_data, instruction, control_signals);
endinterface

// File: rtl/kamacore_lsu_align.sv
// Byte-lane steering for the memory stage: store byte enables and lane
// replication, load shift and sign/zero extension, and misalignment detection.
module kamacore_lsu_align
    import kamacore_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misaligned
);
    logic [31:0] shifted;

    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        be         = 4'b1111;
        wdata      = rs2;
        ld_data    = shifted;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{rs2[7:0]}};
                ld_data = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                           : {24'b0, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {2{rs2[15:0]}};
                ld_data    = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                              : {16'b0, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            // Word and any unused encoding behave as a full-word access.
            default: misaligned = |addr_lo;
        endcase
    end
endmodule

// File: rtl/kamacore_stage_mem.sv
// kamacore memory-access stage: drives the data bus via req/gnt/rvalid,
// formats load/store data, and registers MEM/WB while stalling upstream.
module kamacore_stage_mem
    import kamacore_pkg::*;
#(
    parameter int CPU_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    kamacore_pipeline_stage.rd    pipeline_ex_mem,
    kamacore_pipeline_stage.wr    pipeline_mem_wb,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [CPU_WIDTH-1:0]  dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [CPU_WIDTH-1:0]  dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [CPU_WIDTH-1:0]  dmem_rdata,
    output logic                  stall,
    output logic                  misaligned
);
    logic [6:0]           opcode;
    logic                 is_load;
    logic                 is_store;
    logic [3:0]           be;
    logic [CPU_WIDTH-1:0] wdata;
    logic [CPU_WIDTH-1:0] ld_data;
    logic                 mis_flag;
    logic                 ld_capture;

    mem_state_t           state_q, state_d;
    logic [CPU_WIDTH-1:0] wb_alu_q, wb_alu_d;
    logic [CPU_WIDTH-1:0] wb_mem_q, wb_mem_d;
    logic [CPU_WIDTH-1:0] wb_instr_q, wb_instr_d;
    logic [CTRL_W-1:0]    wb_ctrl_q, wb_ctrl_d;

    assign opcode   = pipeline_ex_mem.instruction[6:0];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);

    kamacore_lsu_align u_align (
        .addr_lo    (pipeline_ex_mem.alu_result[1:0]),
        .funct3     (pipeline_ex_mem.instruction[14:12]),
        .rs2        (pipeline_ex_mem.rs2_data),
        .rdata      (dmem_rdata),
        .be         (be),
        .wdata      (wdata),
        .ld_data    (ld_data),
        .misaligned (mis_flag)
    );

    // Bus address/data come straight from EX/MEM, which is frozen while stalled.
    assign dmem_we    = is_store;
    assign dmem_addr  = {pipeline_ex_mem.alu_result[CPU_WIDTH-1:2], 2'b00};
    assign dmem_be    = be;
    assign dmem_wdata = wdata;

    always_comb begin
        state_d    = state_q;
        dmem_req   = 1'b0;
        stall      = 1'b0;
        misaligned = 1'b0;
        ld_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_load || is_store) begin
                    if (mis_flag) begin
                        misaligned = 1'b1;
                    end else begin
                        dmem_req = 1'b1;
                        if (!dmem_gnt) begin
                            state_d = REQ;
                            stall   = 1'b1;
                        end else if (is_load) begin
                            state_d = WAIT;
                            stall   = 1'b1;
                        end
                    end
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                if (!dmem_gnt) begin
                    stall = 1'b1;
                end else if (is_load) begin
                    state_d = WAIT;
                    stall   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_d    = IDLE;
                    ld_capture = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            state_d    = IDLE;
            dmem_req   = 1'b0;
            stall      = 1'b0;
            misaligned = 1'b0;
        end
    end

    always_comb begin
        wb_alu_d   = '0;
        wb_mem_d   = '0;
        wb_instr_d = '0;
        wb_ctrl_d  = '0;
        if (!stall) begin
            wb_alu_d   = pipeline_ex_mem.alu_result;
            wb_mem_d   = ld_capture ? ld_data : '0;
            wb_instr_d = pipeline_ex_mem.instruction;
            wb_ctrl_d  = pipeline_ex_mem.control_signals;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wb_alu_q   <= '0;
            wb_mem_q   <= '0;
            wb_instr_q <= '0;
            wb_ctrl_q  <= '0;
        end else begin
            state_q    <= state_d;
            wb_alu_q   <= wb_alu_d;
            wb_mem_q   <= wb_mem_d;
            wb_instr_q <= wb_instr_d;
            wb_ctrl_q  <= wb_ctrl_d;
        end
    end

    assign pipeline_mem_wb.alu_result      = wb_alu_q;
    assign pipeline_mem_wb.mem_data        = wb_mem_q;
    assign pipeline_mem_wb.instruction     = wb_instr_q;
    assign pipeline_mem_wb.control_signals = wb_ctrl_q;
    assign pipeline_mem_wb.rs2_data        = '0;
endmodule

// File: tb/tb_kamacore_stage_mem.sv
// Self-checking bench for kamacore_stage_mem: directed vector table, reset
// corner sequences, and randomized ops checked against a behavioural model.
module tb_kamacore_stage_mem;
    import kamacore_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, stall, misaligned;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    kamacore_pipeline_stage ex_mem ();
    kamacore_pipeline_stage mem_wb ();

    always #5 clk = ~clk;

    kamacore_stage_mem #(.CPU_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .pipeline_ex_mem (ex_mem),
        .pipeline_mem_wb (mem_wb),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_gnt        (dmem_gnt),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata),
        .stall           (stall),
        .misaligned      (misaligned)
    );

    typedef struct {
        logic [31:0]       instr, alu, rs2, rdata;
        logic [CTRL_W-1:0] ctrl;
        int                gnt_dly, rv_dly;
        bit                stray;
    } op_t;

    typedef struct {
        logic [31:0] mem, wdata;
        logic [3:0]  be;
        int          stall, req, mis;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t ex;
    } vec_t;

    typedef struct {
        logic [31:0]       wb_alu, wb_mem, wb_instr, wdata, addr;
        logic [CTRL_W-1:0] wb_ctrl;
        logic [3:0]        be;
        logic              we;
        int                stall, req, mis, unstable, bubble_bad;
        bit                timeout;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3);
        return {17'h0AB5, f3, 5'd5, opc};
    endfunction

    // Reference: access size in bytes, natural alignment, lane replication.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int          size, a;
        bit          is_ld, is_st;
        logic [2:0]  f3;
        logic [31:0] v, mask;
        e     = '{default: 0};
        a     = int'(op.alu[1:0]);
        f3    = op.instr[14:12];
        is_ld = (op.instr[6:0] == 7'b0000011);
        is_st = (op.instr[6:0] == 7'b0100011);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (!(is_ld || is_st)) return e;
        if ((a % size) != 0) begin
            e.mis = 1;
            return e;
        end
        e.req = op.gnt_dly + 1;
        e.be  = 4'(((1 << size) - 1) << a);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = op.rs2[8*(i % size) +: 8];
        if (is_st) begin
            e.stall = op.gnt_dly;
        end else begin
            e.stall = op.gnt_dly + op.rv_dly;
            mask    = 32'((64'd1 << (8 * size)) - 64'd1);
            v       = (op.rdata >> (8 * a)) & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            e.mem = v;
        end
        return e;
    endfunction

    task automatic do_op(input op_t op, output obs_t ob);
        int gcyc;
        bit gg, done, first, st, rv;
        ob = '{default: 0};
        ex_mem.instruction     = op.instr;
        ex_mem.alu_result      = op.alu;
        ex_mem.rs2_data        = op.rs2;
        ex_mem.control_signals = op.ctrl;
        gg = 0; gcyc = 0; first = 1; done = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            rv          = gg ? (cyc == gcyc + op.rv_dly) : (op.stray && cyc < op.gnt_dly);
            dmem_gnt    = (!gg && cyc == op.gnt_dly);
            dmem_rvalid = rv;
            dmem_rdata  = (gg && rv) ? op.rdata : $urandom;
            @(negedge clk);
            if (dmem_req) begin
                ob.req++;
                if (first) begin
                    ob.be = dmem_be; ob.wdata = dmem_wdata; ob.we = dmem_we; ob.addr = dmem_addr;
                    first = 0;
                end else if ({dmem_be, dmem_wdata, dmem_we, dmem_addr} !== {ob.be, ob.wdata, ob.we, ob.addr}) begin
                    ob.unstable++;
                end
                if (dmem_gnt) begin
                    gg   = 1;
                    gcyc = cyc;
                end
            end
            if (misaligned) ob.mis++;
            st = stall;
            if (st) ob.stall++;
            done = !st;
            @(posedge clk);
            #1;
            if (st && (mem_wb.instruction !== 32'h0 || mem_wb.control_signals !== '0)) ob.bubble_bad++;
        end
        ob.timeout  = !done;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        ob.wb_alu   = mem_wb.alu_result;
        ob.wb_mem   = mem_wb.mem_data;
        ob.wb_instr = mem_wb.instruction;
        ob.wb_ctrl  = mem_wb.control_signals;
    endtask

    task automatic check_op(input string tag, input op_t op, input exp_t e, input obs_t ob);
        chk({tag, ".timeout"}, 32'(ob.timeout), 32'd0);
        chk({tag, ".wb_alu"}, ob.wb_alu, op.alu);
        chk({tag, ".wb_instr"}, ob.wb_instr, op.instr);
        chk({tag, ".wb_ctrl"}, 32'(ob.wb_ctrl), 32'(op.ctrl));
        chk({tag, ".wb_mem"}, ob.wb_mem, e.mem);
        chk({tag, ".stall_cycles"}, ob.stall, e.stall);
        chk({tag, ".req_cycles"}, ob.req, e.req);
        chk({tag, ".mis_pulses"}, ob.mis, e.mis);
        chk({tag, ".bubble"}, ob.bubble_bad, 0);
        chk({tag, ".req_stable"}, ob.unstable, 0);
        if (e.req > 0) begin
            chk({tag, ".be"}, 32'(ob.be), 32'(e.be));
            chk({tag, ".addr"}, ob.addr, {op.alu[31:2], 2'b00});
            chk({tag, ".we"}, 32'(ob.we), 32'(op.instr[6:0] == 7'b0100011));
            if (op.instr[6:0] == 7'b0100011) chk({tag, ".wdata"}, ob.wdata, e.wdata);
        end
    endtask

    function automatic vec_t mkv(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] alu,
                                 input logic [31:0] rs2, input int gd, input int rd, input logic [31:0] rdata,
                                 input bit stray, input logic [31:0] mem, input int st, input int rq,
                                 input int mis, input logic [3:0] be, input logic [31:0] wd);
        vec_t v;
        v.op = '{instr: mk_instr(opc, f3), alu: alu, rs2: rs2, rdata: rdata, ctrl: 16'h5A00 | 16'(alu[7:0]),
                 gnt_dly: gd, rv_dly: rd, stray: stray};
        v.ex = '{mem: mem, wdata: wd, be: be, stall: st, req: rq, mis: mis};
        return v;
    endfunction

    vec_t tv[12];
    obs_t ob;
    op_t  op;
    exp_t e;
    int   r;
    logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        // opcode, f3, alu, rs2, gnt_dly, rv_dly, rdata, stray | mem, stall, req, mis, be, wdata
        tv[0]  = mkv(7'h23, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0, 0, 32'h0, 0, 1, 0, 4'hF, 32'hDEADBEEF);
        tv[1]  = mkv(7'h23, 3'd0, 32'h103, 32'h000000A5, 2, 1, 32'h0, 0, 32'h0, 2, 3, 0, 4'h8, 32'hA5A5A5A5);
        tv[2]  = mkv(7'h03, 3'd0, 32'h202, 32'h0, 0, 1, 32'h00800000, 0, 32'hFFFFFF80, 1, 1, 0, 4'h4, 32'h0);
        tv[3]  = mkv(7'h03, 3'd4, 32'h202, 32'h0, 0, 1, 32'h00800000, 0, 32'h00000080, 1, 1, 0, 4'h4, 32'h0);
        tv[4]  = mkv(7'h03, 3'd2, 32'h301, 32'h0, 0, 1, 32'h12345678, 0, 32'h0, 0, 0, 1, 4'h0, 32'h0);
        tv[5]  = mkv(7'h33, 3'd0, 32'h1234, 32'h55, 0, 1, 32'h0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
        tv[6]  = mkv(7'h03, 3'd1, 32'h102, 32'h0, 1, 2, 32'h80010000, 0, 32'hFFFF8001, 3, 2, 0, 4'hC, 32'h0);
        tv[7]  = mkv(7'h23, 3'd1, 32'h202, 32'h1234ABCD, 0, 1, 32'h0, 0, 32'h0, 0, 1, 0, 4'hC, 32'hABCDABCD);
        tv[8]  = mkv(7'h03, 3'd5, 32'h105, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 1, 4'h0, 32'h0);
        tv[9]  = mkv(7'h03, 3'd2, 32'h400, 32'h0, 1, 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 2, 2, 0, 4'hF, 32'h0);
        tv[10] = mkv(7'h23, 3'd0, 32'h101, 32'h0000003C, 3, 1, 32'h0, 1, 32'h0, 3, 4, 0, 4'h2, 32'h3C3C3C3C);
        tv[11] = mkv(7'h03, 3'd5, 32'h106, 32'h0, 0, 3, 32'hBEEF1234, 0, 32'h0000BEEF, 3, 1, 0, 4'hC, 32'h0);

        // Reset with a misaligned load and a gnt/rvalid present: everything must stay quiet.
        rst = 1'b0;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        ex_mem.mem_data = 32'h0;
        ex_mem.instruction = mk_instr(7'h03, 3'd2); ex_mem.alu_result = 32'h301;
        ex_mem.rs2_data = 32'h0; ex_mem.control_signals = 16'hFFFF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.mis", 32'(misaligned), 32'd0);
        @(posedge clk); #1;
        chk("rst.wb", mem_wb.alu_result | mem_wb.mem_data | mem_wb.instruction | 32'(mem_wb.control_signals), 32'h0);
        rst = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(tv[i].op, ob);
            check_op($sformatf("vec%0d", i), tv[i].op, tv[i].ex, ob);
        end

        // Load abandoned by reset while waiting; late rvalid must be ignored.
        op = '{instr: mk_instr(7'h03, 3'd2), alu: 32'h500, rs2: 32'h0, rdata: 32'h600DF00D,
               ctrl: 16'h0042, gnt_dly: 0, rv_dly: 1, stray: 0};
        ex_mem.instruction = op.instr; ex_mem.alu_result = op.alu;
        ex_mem.rs2_data = op.rs2; ex_mem.control_signals = op.ctrl;
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("abort.gnt_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("abort.rst_req", 32'(dmem_req), 32'd0);
        chk("abort.rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort.wb_clear", mem_wb.alu_result | mem_wb.mem_data | mem_wb.instruction | 32'(mem_wb.control_signals), 32'h0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("abort.idle_req", 32'(dmem_req), 32'd1);
        chk("abort.late_rv_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        chk("abort.late_rv_mem", mem_wb.mem_data, 32'h0);
        chk("abort.late_rv_instr", mem_wb.instruction, 32'h0);
        dmem_rvalid = 1'b0;
        do_op(op, ob);
        check_op("abort.retry", op, model(op), ob);

        // Randomized back-to-back ops against the reference model.
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            op.alu     = $urandom;
            op.rs2     = $urandom;
            op.rdata   = $urandom;
            op.ctrl    = CTRL_W'($urandom);
            op.gnt_dly = $urandom_range(0, 3);
            op.rv_dly  = $urandom_range(1, 3);
            op.stray   = 1'($urandom_range(0, 1));
            if (r < 4)      op.instr = {$urandom_range(0, 131071), ld_f3[$urandom_range(0, 4)], 5'd7, 7'b0000011};
            else if (r < 8) op.instr = {$urandom_range(0, 131071), 3'($urandom_range(0, 2)), 5'd7, 7'b0100011};
            else            op.instr = {$urandom_range(0, 131071), 3'($urandom), 5'd7, 7'b0110011};
            op.instr[31:15] = 17'($urandom);
            e = model(op);
            do_op(op, ob);
            check_op($sformatf("rand%0d", n), op, e, ob);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
